// File: rtl/matrix_row_store.sv
// matrix_row_store
//   Captures four-lane matrix-multiply result rows with their destination base
//   address, buffers them in a DEPTH-row FIFO and drains each row to data
//   memory as four sequential 32-bit word stores (lane i at base + 4*i).
//
// Ports
//   clk, rst            core clock; synchronous active-high reset
//   row_valid           a result row is presented this cycle
//   row_data[3:0]       result lanes, 32 bits each
//   row_base            byte address of lane 0 (bits [1:0] ignored)
//   row_ready           FIFO can accept a row this cycle
//   mem_we              word store request
//   mem_addr/mem_wdata  address and data of the current word
//   mem_ready           memory accepts the store this cycle
//   busy                FIFO non-empty
//   row_done            pulse: last word of a row accepted this cycle
module matrix_row_store #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  input  logic [3:0][31:0] row_data,
  input  logic [31:0]      row_base,
  output logic             row_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  output logic             busy,
  output logic             row_done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    STORE
  } state_t;

  logic [29:0]      base_mem [DEPTH];
  logic [3:0][31:0] data_mem [DEPTH];

  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_n;
  logic [1:0]    wi;
  state_t        state, state_n;
  logic          push, beat, pop;

  // STORE tracks count != 0 exactly, so the state register doubles as the
  // registered "FIFO non-empty" flag driving mem_we and busy.
  always_comb begin
    row_ready = !rst && (count != FULL);
    push      = row_valid && row_ready;
    mem_we    = !rst && (state == STORE);
    busy      = mem_we;
    beat      = mem_we && mem_ready;
    pop       = beat && (wi == 2'd3);
    row_done  = pop;
    mem_addr  = {base_mem[rp], 2'b00} + {28'd0, wi, 2'b00};
    mem_wdata = data_mem[rp][wi];

    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase

    state_n = (count_n != '0) ? STORE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wp    <= '0;
      rp    <= '0;
      wi    <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (push) wp <= wp + 1'b1;
      if (beat) wi <= wi + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Entry storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      base_mem[wp] <= row_base[31:2];
      data_mem[wp] <= row_data;
    end
  end

endmodule

// File: tb/tb_matrix_row_store.sv
// Testbench for matrix_row_store: directed scenarios followed by random
// traffic; a monitor compares every presented store against a queue of
// expected word stores built from each accepted row.
module tb_matrix_row_store;

  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             row_valid;
  logic [3:0][31:0] row_data;
  logic [31:0]      row_base;
  logic             row_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic             busy;
  logic             row_done;

  always #5 clk = ~clk;

  matrix_row_store #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_base  (row_base),
    .row_ready (row_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .row_done  (row_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } store_t;

  store_t exp_q[$];
  int     rows   = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled at the falling edge; the model then advances
  // to reflect the rising edge that follows.
  always @(negedge clk) begin : mon
    bit     we_m;
    bit     beat_m;
    bit     acc_m;
    store_t s;
    logic [31:0] base_al;
    we_m   = !rst && (rows != 0);
    beat_m = we_m && mem_ready;
    acc_m  = row_valid && !rst && (rows < int'(DEPTH));
    chk("mem_we", 32'(mem_we), 32'(we_m));
    chk("busy", 32'(busy), 32'(we_m));
    chk("row_ready", 32'(row_ready), 32'(!rst && (rows < int'(DEPTH))));
    if (we_m) begin
      s = exp_q[0];
      chk("mem_addr", mem_addr, s.addr);
      chk("mem_wdata", mem_wdata, s.data);
      chk("row_done", 32'(row_done), 32'(beat_m && s.last));
      if (beat_m) begin
        void'(exp_q.pop_front());
        if (s.last) rows--;
      end
    end else begin
      chk("row_done_idle", 32'(row_done), 32'd0);
    end
    if (rst) begin
      exp_q.delete();
      rows = 0;
    end else if (acc_m) begin
      base_al = {row_base[31:2], 2'b00};
      for (int i = 0; i < 4; i++) begin
        s.addr = base_al + 32'(4 * i);
        s.data = row_data[i];
        s.last = (i == 3);
        exp_q.push_back(s);
      end
      rows++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] seed);
    row_valid = 1'b1;
    row_base  = b;
    for (int i = 0; i < 4; i++) row_data[i] = seed + 32'(i);
    step();
    row_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while ((rows != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: rows %0d busy %0b expected 0 0", rows, busy);
    end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    row_valid = 1'b0;
    row_base  = '0;
    row_data  = '0;
    mem_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step();

    // single row
    push(32'h100, 32'hA0);
    step(6);

    // stall on word 2
    push(32'h100, 32'hA0);
    step(2);
    mem_ready = 1'b0;
    step(3);
    mem_ready = 1'b1;
    step(4);

    // fill to DEPTH; fifth row must be ignored
    mem_ready = 1'b0;
    push(32'h0,  32'h1000);
    push(32'h10, 32'h1010);
    push(32'h20, 32'h1020);
    push(32'h30, 32'h1030);
    push(32'h40, 32'h1040);
    drain();

    // push lands in the row_done cycle of the head row
    mem_ready = 1'b1;
    push(32'h200, 32'h2000);
    push(32'h300, 32'h3000);
    step(2);
    push(32'h400, 32'h4000);
    drain();

    // address wrap and unaligned base
    push(32'hFFFF_FFF8, 32'h11);
    push(32'h103, 32'h22);
    drain();

    // reset mid-row
    mem_ready = 1'b0;
    push(32'h500, 32'h50);
    push(32'h600, 32'h60);
    mem_ready = 1'b1;
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(2);
    push(32'h700, 32'h70);
    drain();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      row_valid = 1'($urandom_range(0, 1));
      row_base  = $urandom;
      for (int i = 0; i < 4; i++) row_data[i] = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst       = 1'b0;
    row_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_row_store.md
# matrix_row_store

Write-back serializer for the matrix-multiply path: captures the four-lane result row that the execute stage produces (ex_matrix_mul_o[3:0]) together with its destination base address, buffers rows in a small FIFO, and drains each row to data memory as four sequential 32-bit word stores. It sits between the EX/MEM pipeline register and the data-memory write port. Backpressure is returned to the hazard unit through row_ready.

## Interface
- DEPTH, 4, FIFO depth in rows; power of two, ≥2.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- row_valid  input  1  a result row is presented this cycle.
- row_data[3:0]  input  32 each  result lanes; lane i is stored at base + 4*i.
- row_base  input  32  byte address of lane 0 (word aligned; bits [1:0] ignored, forced 0 on output).
- row_ready  output  1  FIFO can accept a row this cycle.
- mem_we  output  1  word store request.
- mem_addr  output  32  byte address of current word.
- mem_wdata  output  32  data of current word.
- mem_ready  input  1  memory accepts the store this cycle.
- busy  output  1  FIFO non-empty (store in progress).
- row_done  output  1  one-cycle pulse: last word of a row accepted this cycle.

## Operation
- Storage: DEPTH entries of {base[31:2], data[3:0]}; write pointer wp, read pointer rp (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH), word index wi (2 bits).
- Push: row_valid && row_ready → write entry at wp, wp+1. row_ready = !rst && (count != DEPTH). No same-cycle pop bypass: a full FIFO deasserts row_ready even if a pop occurs that cycle.
- Drain FSM: IDLE (count==0) / STORE (count>0). mem_we = (count != 0). mem_addr = {head.base, 2'b00} + {wi, 2'b00}, 32-bit modular add (wrap past 0xFFFFFFFC is legal, no carry out). mem_wdata = head.data[wi].
- Beat: mem_we && mem_ready → wi+1. When wi==3 and beat: wi→0, rp+1, row_done=1.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Push into empty FIFO: entry visible at head next cycle; never stored in the same cycle it is accepted.
- mem_ready ignored when mem_we=0. mem_addr/mem_wdata hold stable while mem_we=1 and mem_ready=0.
- busy = (count != 0).
- Reset (any cycle, including mid-row): count, wp, rp, wi ← 0; mem_we, busy, row_done, row_ready all 0 while rst high; buffered rows discarded; entry contents need not be cleared.

## Timing
- Reset values: row_ready 0 (during rst), then 1 the first cycle after rst falls; mem_we 0, busy 0, row_done 0, mem_addr/mem_wdata don't-care while mem_we=0.
- Latency: row accepted at edge k → first word presented (mem_we=1) in cycle k+1.
- Throughput with mem_ready=1: one word per cycle, one row per 4 cycles; back-to-back rows produce unbroken mem_we with no bubble between rows.
- row_done asserted combinationally in the cycle of the fourth accepted beat; busy falls the cycle after the final row_done if no push occurred.
- row_ready recovers the cycle after the pop that drops count below DEPTH.

## Test plan
- Single row: rst 2 cycles, push base=0x100, data={0xA0,0xA1,0xA2,0xA3}, mem_ready=1 → cycles k+1..k+4 stores (0x100,0xA0),(0x104,0xA1),(0x108,0xA2),(0x10C,0xA3); row_done only at k+4; busy 0 at k+5.
- Stall: same row, mem_ready=0 for 3 cycles on word 2 → mem_addr held at 0x108, wdata 0xA2, no row_done until 4th beat accepted; exactly 4 stores total.
- Full: mem_ready=0, push DEPTH=4 rows (bases 0x0,0x10,0x20,0x30) → row_ready 0 after fourth push; 5th row_valid ignored; release mem_ready → 16 stores in order, row_ready 1 the cycle after first row_done.
- Simultaneous push/pop: count=2, push on the cycle of row_done → count stays 2; stream order preserved, no gap in mem_we.
- Wrap: base=0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; base=0x103 → first address 0x100.
- Reset mid-row: assert rst after word 1 of a 2-row queue → mem_we 0 next cycle, busy 0, no further stores; new row after rst starts at wi=0.
